// File: rtl/dram_pkg.sv
// dram_pkg: address-field widths shared by the DRAM command sequencer and
// the signal generator it drives.
package dram_pkg;

    localparam int RANK_BITS       = 1;
    localparam int BANK_GROUP_BITS = 2;
    localparam int BANK_BITS       = 2;
    localparam int ROW_BITS        = 16;
    localparam int COLUMN_BITS     = 10;

endpackage : dram_pkg

// File: rtl/dram_cmd_fsm.sv
// dram_cmd_fsm: DRAM command sequencer (one request at a time, single open
// row). Spaces ACTIVATE/READ/WRITE/PRECHARGE/REFRESH commands by the DRAM
// timing parameters, schedules periodic refresh, and drives the signal
// generator's control inputs.
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (accepted when both high)
//   req_write            1 = write, 0 = read
//   req_rank/bg/ba/row/col  request address fields
//   rw_done              one-cycle pulse when a read/write completes
//   ref_re               high exactly in the REFRESH command cycle
//   state / nstate       current / next state encoding
//   RA0, BG0, BA0, R0, C0  registered command address fields
//
// Build option: define DRAM_AUTO_PRECHARGE_EN for closed-page operation
// (every access ends with PRECHARGE); default is open-page.
module dram_cmd_fsm
    import dram_pkg::*;
#(
    parameter int tRCD         = 16,
    parameter int tRP          = 16,
    parameter int tCL          = 16,
    parameter int tCWL         = 12,
    parameter int tWR          = 18,
    parameter int BURST_CYCLES = 4,
    parameter int tRFC         = 420,
    parameter int tREFI        = 9360,
    parameter int CNT_W        = 16
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [RANK_BITS-1:0]       req_rank,
    input  logic [BANK_GROUP_BITS-1:0] req_bg,
    input  logic [BANK_BITS-1:0]       req_ba,
    input  logic [ROW_BITS-1:0]        req_row,
    input  logic [COLUMN_BITS-1:0]     req_col,
    output logic                       rw_done,
    output logic                       ref_re,
    output logic [3:0]                 state,
    output logic [3:0]                 nstate,
    output logic [RANK_BITS-1:0]       RA0,
    output logic [BANK_GROUP_BITS-1:0] BG0,
    output logic [BANK_BITS-1:0]       BA0,
    output logic [ROW_BITS-1:0]        R0,
    output logic [COLUMN_BITS-1:0]     C0
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ACTIVATE  = 4'd1,
        S_ACT_WAIT  = 4'd2,
        S_READ      = 4'd3,
        S_WRITE     = 4'd4,
        S_RW_WAIT   = 4'd5,
        S_PRECHARGE = 4'd6,
        S_PRE_WAIT  = 4'd7,
        S_REFRESH   = 4'd8,
        S_REF_WAIT  = 4'd9
    } state_t;

    // Wait states exit when the timer reaches zero. The timer is loaded in
    // the command cycle with (spacing - 2), so the next command lands exactly
    // "spacing" cycles after the previous one.
    localparam logic [CNT_W-1:0] LOAD_RCD   = CNT_W'(tRCD - 2);
    localparam logic [CNT_W-1:0] LOAD_RP    = CNT_W'(tRP - 2);
    localparam logic [CNT_W-1:0] LOAD_RFC   = CNT_W'(tRFC - 2);
    localparam logic [CNT_W-1:0] LOAD_RD    = CNT_W'(tCL + BURST_CYCLES - 2);
    localparam logic [CNT_W-1:0] LOAD_WR    = CNT_W'(tCWL + BURST_CYCLES + tWR - 2);
    localparam logic [CNT_W-1:0] REFI_LAST  = CNT_W'(tREFI - 1);

    state_t cur_state, nxt_state;

    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] ref_cnt;
    logic             ref_pending;
    logic             ref_expire;

    // Latched request
    logic                       req_pending;
    logic                       wr_q;
    logic [RANK_BITS-1:0]       rank_q;
    logic [BANK_GROUP_BITS-1:0] bg_q;
    logic [BANK_BITS-1:0]       ba_q;
    logic [ROW_BITS-1:0]        row_q;
    logic [COLUMN_BITS-1:0]     col_q;

    // Open-row tracking
    logic                       row_open;
    logic [RANK_BITS-1:0]       open_rank;
    logic [BANK_GROUP_BITS-1:0] open_bg;
    logic [BANK_BITS-1:0]       open_ba;
    logic [ROW_BITS-1:0]        open_row;

    logic accept;
    logic hit;
    logic timer_zero;

    assign req_ready  = (cur_state == S_IDLE) && !ref_pending;
    assign accept     = req_valid && req_ready;
    assign hit        = row_open && (req_rank == open_rank) && (req_bg == open_bg)
                        && (req_ba == open_ba) && (req_row == open_row);
    assign timer_zero = (timer == '0);
    assign ref_expire = (ref_cnt == REFI_LAST);
    assign state      = cur_state;
    assign nstate     = nxt_state;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) cur_state <= S_IDLE;
        else       cur_state <= nxt_state;
    end

    // NOTE: nxt_state is given a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE: begin
                if (ref_pending && row_open)      nxt_state = S_PRECHARGE;
                else if (ref_pending)             nxt_state = S_REFRESH;
                else if (req_valid) begin
                    if (hit)                      nxt_state = req_write ? S_WRITE : S_READ;
                    else if (row_open)            nxt_state = S_PRECHARGE;
                    else                          nxt_state = S_ACTIVATE;
                end
            end
            S_ACTIVATE:  nxt_state = S_ACT_WAIT;
            S_ACT_WAIT:  if (timer_zero) nxt_state = wr_q ? S_WRITE : S_READ;
            S_READ,
            S_WRITE:     nxt_state = S_RW_WAIT;
            S_RW_WAIT: begin
                if (timer_zero) begin
`ifdef DRAM_AUTO_PRECHARGE_EN
                    nxt_state = S_PRECHARGE;
`else
                    nxt_state = S_IDLE;
`endif
                end
            end
            S_PRECHARGE: nxt_state = S_PRE_WAIT;
            S_PRE_WAIT: begin
                // A row-miss precharge continues to ACTIVATE; a refresh-driven
                // one goes straight to REFRESH.
                if (timer_zero) begin
                    if (req_pending)      nxt_state = S_ACTIVATE;
                    else if (ref_pending) nxt_state = S_REFRESH;
                    else                  nxt_state = S_IDLE;
                end
            end
            S_REFRESH:   nxt_state = S_REF_WAIT;
            S_REF_WAIT:  if (timer_zero) nxt_state = S_IDLE;
            default:     nxt_state = S_IDLE;
        endcase
    end

    // Command spacing timer
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            timer <= '0;
        end else begin
            case (cur_state)
                S_ACTIVATE:  timer <= LOAD_RCD;
                S_PRECHARGE: timer <= LOAD_RP;
                S_REFRESH:   timer <= LOAD_RFC;
                S_READ:      timer <= LOAD_RD;
                S_WRITE:     timer <= LOAD_WR;
                S_ACT_WAIT, S_RW_WAIT, S_PRE_WAIT, S_REF_WAIT:
                    if (!timer_zero) timer <= timer - 1'b1;
                default:     timer <= timer;
            endcase
        end
    end

    // Refresh interval counter; ref_pending is sticky and a fresh expiry
    // wins over the clear in the REFRESH cycle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
        end else begin
            ref_cnt     <= ref_expire ? '0 : ref_cnt + 1'b1;
            ref_pending <= ref_expire || (ref_pending && (cur_state != S_REFRESH));
        end
    end

    // Request latch
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            req_pending <= 1'b0;
            wr_q        <= 1'b0;
            rank_q      <= '0;
            bg_q        <= '0;
            ba_q        <= '0;
            row_q       <= '0;
            col_q       <= '0;
        end else begin
            if (accept) begin
                req_pending <= 1'b1;
                wr_q        <= req_write;
                rank_q      <= req_rank;
                bg_q        <= req_bg;
                ba_q        <= req_ba;
                row_q       <= req_row;
                col_q       <= req_col;
            end else if (cur_state == S_READ || cur_state == S_WRITE) begin
                req_pending <= 1'b0;
            end
        end
    end

    // Open-row tracking
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            row_open  <= 1'b0;
            open_rank <= '0;
            open_bg   <= '0;
            open_ba   <= '0;
            open_row  <= '0;
        end else if (cur_state == S_ACTIVATE) begin
            row_open  <= 1'b1;
            open_rank <= rank_q;
            open_bg   <= bg_q;
            open_ba   <= ba_q;
            open_row  <= row_q;
        end else if (cur_state == S_PRECHARGE) begin
            row_open  <= 1'b0;
        end
    end

    // Registered command outputs. Address fields are loaded from the next
    // state so they are valid during the command cycle itself; on the
    // accepting edge the incoming request is used directly.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            RA0     <= '0;
            BG0     <= '0;
            BA0     <= '0;
            R0      <= '0;
            C0      <= '0;
            rw_done <= 1'b0;
            ref_re  <= 1'b0;
        end else begin
            rw_done <= (cur_state == S_RW_WAIT) && timer_zero;
            ref_re  <= (nxt_state == S_REFRESH);
            if (nxt_state == S_PRECHARGE) begin
                RA0 <= open_rank;
                BG0 <= open_bg;
                BA0 <= open_ba;
                R0  <= open_row;
                C0  <= col_q;
            end else if (accept) begin
                RA0 <= req_rank;
                BG0 <= req_bg;
                BA0 <= req_ba;
                R0  <= req_row;
                C0  <= req_col;
            end else begin
                RA0 <= rank_q;
                BG0 <= bg_q;
                BA0 <= ba_q;
                R0  <= row_q;
                C0  <= col_q;
            end
        end
    end

endmodule : dram_cmd_fsm
